// File: rtl/seq_approx_divider_pkg.sv
// Shared types and cell functions for the sequential approximate divider.
// Cells return {bout, diff}.
package seq_approx_divider_pkg;

  localparam int unsigned DIV_DW = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic int unsigned cnt_w(
    input int unsigned dw
  );
    return (dw > 2) ? $clog2(dw) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(DIV_DW);

  function automatic logic [1:0] exact_cell(
    input logic x,
    input logic y,
    input logic bin
  );
    logic bout;
    logic diff;
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, diff};
  endfunction

  function automatic logic [1:0] approx_cell(
    input logic x,
    input logic y,
    input logic bin
  );
    logic bout;
    logic diff;
    bout = (~x & y & ~bin)
         | (x & ~y & bin)
         | (x & y & ~bin);
    diff = (~x & ~bin)
         | (x & ~y & ~bin)
         | (x & y & bin);
    return {bout, diff};
  endfunction

endpackage

// File: rtl/seq_approx_divider_div_row.sv
// One restoring-division row: borrow ripples from column 0 upwards,
// using approximate cells in the low triangle when enabled.
module div_row
  import seq_approx_divider_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned APPROX_K = 4
) (
  input  logic [DW-1:0]        x_i,
  input  logic                 t_i,
  input  logic [DW-1:0]        d_i,
  input  logic [cnt_w(DW)-1:0] k_i,
  input  logic                 approx_en_i,
  output logic                 q_bit_o,
  output logic [DW-1:0]        r_next_o
);

  logic [DW-1:0] diff;
  logic [1:0]    c;
  logic          b;

  always_comb begin
    diff = '0;
    c    = '0;
    b    = 1'b0;
    for (int j = 0; j < DW; j++) begin
      if (approx_en_i &&
          (j + int'(k_i)) < int'(APPROX_K)) begin
        c = approx_cell(x_i[j], d_i[j], b);
      end else begin
        c = exact_cell(x_i[j], d_i[j], b);
      end
      diff[j] = c[0];
      b       = c[1];
    end
    q_bit_o  = t_i | ~b;
    r_next_o = q_bit_o ? diff : x_i;
  end

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative NW/DW restoring divider, one quotient bit per clock,
// with run-time approximate low triangle, dbz and overflow flags.
module seq_approx_divider
  import seq_approx_divider_pkg::*;
#(
  parameter int unsigned DW       = DIV_DW,
  parameter int unsigned NW       = 2 * DW,
  parameter int unsigned APPROX_K = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  input  logic          approx_en,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r,
  output logic          dbz,
  output logic          ovf
);

  localparam int unsigned KW =
    (DW == DIV_DW) ? CNT_W : cnt_w(DW);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [NW-1:0] n_q, n_d;
  logic [DW-1:0] d_q, d_d;
  logic          apx_q, apx_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] qw_q, qw_d;
  logic          ovp_q, ovp_d;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic          first;
  logic [DW-1:0] row_x;
  logic          row_t;
  logic          q_bit;
  logic [DW-1:0] r_next;

  // First row takes its operand straight from the dividend.
  assign first = (k_q == KW'(DW - 1));
  assign row_x = first ? n_q[NW-2:DW-1]
                       : {rem_q[DW-2:0], n_q[k_q]};
  assign row_t = first ? n_q[NW-1] : rem_q[DW-1];

  div_row #(
    .DW       (DW),
    .APPROX_K (APPROX_K)
  ) u_row (
    .x_i         (row_x),
    .t_i         (row_t),
    .d_i         (d_q),
    .k_i         (k_q),
    .approx_en_i (apx_q),
    .q_bit_o     (q_bit),
    .r_next_o    (r_next)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    d_d     = d_q;
    apx_d   = apx_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    ovp_d   = ovp_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = n;
          d_d   = d;
          apx_d = approx_en;
          rem_d = '0;
          qw_d  = '0;
          q_d   = '0;
          r_d   = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          ovp_d = (d != '0) &&
                  (n[NW-1:DW] >= d);
          if (d == '0) begin
            done_d = 1'b1;
            q_d    = '1;
            r_d    = n[DW-1:0];
            dbz_d  = 1'b1;
          end else begin
            state_d = RUN;
            k_d     = KW'(DW - 1);
          end
        end
      end
      RUN: begin
        qw_d[k_q] = q_bit;
        rem_d     = r_next;
        k_d       = k_q - KW'(1);
        if (k_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          q_d     = qw_d;
          r_d     = r_next;
          ovf_d   = ovp_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      d_q     <= '0;
      apx_q   <= 1'b0;
      rem_q   <= '0;
      qw_q    <= '0;
      ovp_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      d_q     <= d_d;
      apx_q   <= apx_d;
      rem_q   <= rem_d;
      qw_q    <= qw_d;
      ovp_q   <= ovp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign q     = q_q;
  assign r     = r_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Bench for seq_approx_divider: vector table, random and corner
// sequences, checked through a queue of expected results.
module tb_seq_approx_divider;

  localparam int DW = 8;
  localparam int NW = 16;
  localparam int AK = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NW-1:0] n;
  logic [DW-1:0] d;
  logic          approx_en;
  logic          ready;
  logic          done;
  logic [DW-1:0] q;
  logic [DW-1:0] r;
  logic          dbz;
  logic          ovf;

  seq_approx_divider #(
    .DW       (DW),
    .NW       (NW),
    .APPROX_K (AK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .d         (d),
    .approx_en (approx_en),
    .ready     (ready),
    .done      (done),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic        ap;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int free_cyc = 0;
  int ndone    = 0;
  bit mon_en   = 0;
  logic mon_due;
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-level model of the triangular array, row by row.
  function automatic void golden(
    input  logic [15:0] nn,
    input  logic [7:0]  dd,
    input  logic        ap,
    output logic [7:0]  qq,
    output logic [7:0]  rr
  );
    logic [7:0] x, rem, df;
    logic t, b, bo, dv, xi, yi;
    rem = '0;
    qq  = '0;
    df  = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k == 7) begin
        x = nn[14:7];
        t = nn[15];
      end else begin
        x = {rem[6:0], nn[k]};
        t = rem[7];
      end
      b = 1'b0;
      for (int j = 0; j < 8; j++) begin
        xi = x[j];
        yi = dd[j];
        if (ap && (j + k) < AK) begin
          bo = (~xi & yi & ~b) | (xi & ~yi & b)
             | (xi & yi & ~b);
          dv = (~xi & ~b) | (xi & ~yi & ~b)
             | (xi & yi & b);
        end else begin
          dv = xi ^ yi ^ b;
          bo = (~xi & yi) | (~(xi ^ yi) & b);
        end
        df[j] = dv;
        b     = bo;
      end
      qq[k] = t | ~b;
      rem   = qq[k] ? df : x;
    end
    rr = rem;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      mon_due = (sb.size() != 0) &&
                (sb[0].due == cyc);
      chk("done_pulse", 32'(done), 32'(mon_due));
      if (done) ndone++;
      if (mon_due) begin
        mon_e = sb.pop_front();
        chk("q",   32'(q),   32'(mon_e.q));
        chk("r",   32'(r),   32'(mon_e.r));
        chk("dbz", 32'(dbz), 32'(mon_e.dbz));
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
  end

  task automatic issue(input logic [15:0] nn,
                       input logic [7:0]  dd,
                       input logic        ap,
                       input logic [7:0]  eq,
                       input logic [7:0]  er,
                       input logic        edbz,
                       input logic        eovf);
    exp_t e;
    int   lat;
    while (cyc < free_cyc) step();
    chk("ready_idle", 32'(ready), 32'd1);
    n         = nn;
    d         = dd;
    approx_en = ap;
    start     = 1'b1;
    lat       = (dd == 8'd0) ? 1 : DW + 1;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.ovf = eovf;
    e.due = cyc + lat;
    sb.push_back(e);
    free_cyc = cyc + lat;
    step();
    start = 1'b0;
    if (dd != 8'd0) begin
      chk("busy", 32'(ready), 32'd0);
      chk("clr_q", 32'(q), 32'd0);
      chk("clr_ovf", 32'(ovf), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++)
      step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left=%0d want=0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_q"},     32'(q),     32'd0);
    chk({tag, "_r"},     32'(r),     32'd0);
    chk({tag, "_dbz"},   32'(dbz),   32'd0);
    chk({tag, "_ovf"},   32'(ovf),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] nn;
    logic [7:0]  dd, eq, er;
    logic        ap, eo;
    int          acc, nd0;

    tbl[0]  = '{16'd200,  8'd7,   1'b0,
                8'd28,    8'd4,   1'b0, 1'b0};
    tbl[1]  = '{16'h1234, 8'd0,   1'b0,
                8'hFF,    8'h34,  1'b1, 1'b0};
    tbl[2]  = '{16'h0900, 8'd8,   1'b0,
                8'hFF,    8'h08,  1'b0, 1'b1};
    tbl[3]  = '{16'h06FF, 8'd7,   1'b0,
                8'hFF,    8'h06,  1'b0, 1'b0};
    tbl[4]  = '{16'h0000, 8'd1,   1'b0,
                8'h00,    8'h00,  1'b0, 1'b0};
    tbl[5]  = '{16'h00FF, 8'hFF,  1'b0,
                8'h01,    8'h00,  1'b0, 1'b0};
    tbl[6]  = '{16'hFEFF, 8'hFF,  1'b0,
                8'hFF,    8'hFE,  1'b0, 1'b0};
    tbl[7]  = '{16'd200,  8'd7,   1'b1,
                8'h1D,    8'h01,  1'b0, 1'b0};
    tbl[8]  = '{16'h0001, 8'd0,   1'b1,
                8'hFF,    8'h01,  1'b1, 1'b0};
    tbl[9]  = '{16'h0700, 8'd7,   1'b0,
                8'hFF,    8'h07,  1'b0, 1'b1};
    tbl[10] = '{16'h1234, 8'h35,  1'b0,
                8'h57,    8'h31,  1'b0, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    n         = '0;
    d         = '0;
    approx_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    idle_zero("reset");
    mon_en = 1;

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].n, tbl[i].d, tbl[i].ap,
            tbl[i].q, tbl[i].r,
            tbl[i].dbz, tbl[i].ovf);
    end
    drain();

    for (int i = 0; i < 30; i++) begin
      nn = 16'($urandom);
      dd = 8'($urandom_range(0, 255));
      ap = 1'($urandom);
      if (i % 3 == 0 && dd != 8'd0)
        nn[15:8] = 8'($urandom_range(0, dd - 1));
      eo = (dd != 0) && (nn[15:8] >= dd);
      if (dd == 8'd0) begin
        eq = 8'hFF;
        er = nn[7:0];
      end else if (!ap && !eo) begin
        eq = 8'(nn / dd);
        er = 8'(nn % dd);
      end else begin
        golden(nn, dd, ap, eq, er);
      end
      issue(nn, dd, ap, eq, er, dd == 0, eo);
    end
    drain();

    // Abort in the third RUN cycle.
    issue(16'd200, 8'd7, 1'b0,
          8'd28, 8'd4, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    free_cyc = cyc;
    idle_zero("abort");
    repeat (12) step();

    // Start held high across several operations.
    nd0   = ndone;
    acc   = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      dd = 8'($urandom_range(1, 255));
      nn = 16'($urandom);
      nn[15:8] = 8'($urandom_range(0, dd - 1));
      n         = nn;
      d         = dd;
      approx_en = 1'b0;
      chk("ready_hold", 32'(ready),
          32'(cyc >= free_cyc));
      if (cyc >= free_cyc) begin
        mon_e.q   = 8'(nn / dd);
        mon_e.r   = 8'(nn % dd);
        mon_e.dbz = 1'b0;
        mon_e.ovf = 1'b0;
        mon_e.due = cyc + DW + 1;
        sb.push_back(mon_e);
        free_cyc = cyc + DW + 1;
        acc++;
      end
      step();
    end
    start = 1'b0;
    drain();
    chk("done_count", 32'(ndone - nd0), 32'(acc));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
